// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, LATENCY wait states, word/byte access.
// Optional misaligned-word trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int ADDR_W  = 6,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        byte_enable,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                enter_resp;

  logic                we_q, be_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         mem_q [DEPTH];

  logic                acc_we, acc_be;
  logic [ADDR_W+1:0]   acc_addr;
  logic [ADDR_W-1:0]   acc_idx;
  logic [1:0]          acc_lane;
  logic                trap;
  logic                unused_addr_hi;

  function automatic logic [31:0] lane_read(input logic [31:0] word, input logic be,
                                            input logic [1:0] lane);
    lane_read = be ? {24'b0, word[8*lane +: 8]} : word;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wd,
                                             input logic be, input logic [1:0] lane);
    logic [31:0] res;
    res = word;
    if (be) res[8*lane +: 8] = wd[7:0];
    else    res = wd;
    lane_merge = res;
  endfunction

  // With zero wait states RESP is entered straight from IDLE, before the latch holds the request.
  assign acc_we   = (state_q == ST_IDLE) ? we                : we_q;
  assign acc_be   = (state_q == ST_IDLE) ? byte_enable       : be_q;
  assign acc_addr = (state_q == ST_IDLE) ? addr[ADDR_W+1:0]  : addr_q;
  assign acc_idx  = acc_addr[ADDR_W+1:2];
  assign acc_lane = acc_addr[1:0];
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = !acc_be && (acc_lane != 2'b00);
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (LATENCY > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_resp) begin
      err_d = trap;
      if (!acc_we && !trap) rdata_d = lane_read(mem_q[acc_idx], acc_be, acc_lane);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request fields are captured only at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && req) begin
      we_q    <= we;
      be_q    <= byte_enable;
      addr_q  <= addr[ADDR_W+1:0];
      wdata_q <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state_q == ST_RESP && we_q && !trap)
      mem_q[acc_idx] <= lane_merge(mem_q[acc_idx], wdata_q, be_q, acc_lane);
  end

  assign rdata = rdata_q;
  assign ready = (state_q == ST_RESP);
  assign busy  = (state_q != ST_IDLE);
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 0) against an array-based reference model.
module tb_dmem_responder;
  localparam int AW = 6;
  localparam int NW = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_s   [2];
  logic        we_s    [2];
  logic        be_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];
  logic        ready_s [2];
  logic        busy_s  [2];
  logic        err_s   [2];

  logic [31:0] mem_m   [2][NW];
  logic [31:0] rdata_m [2];
  int          lat_m   [2] = '{2, 0};
  int          passes = 0;
  int          fails  = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(AW), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .req(req_s[0]), .we(we_s[0]), .byte_enable(be_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ready(ready_s[0]),
    .busy(busy_s[0]), .err(err_s[0]));

  dmem_responder #(.ADDR_W(AW), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(reset), .req(req_s[1]), .we(we_s[1]), .byte_enable(be_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ready(ready_s[1]),
    .busy(busy_s[1]), .err(err_s[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transfer on instance d, checked and folded into the model.
  task automatic xfer(input int d, input logic w, input logic b, input logic [31:0] a,
                      input logic [31:0] wd);
    int          idx, lane, got;
    logic        trap;
    logic [31:0] word, mask;
    idx  = int'((a >> 2) % NW);
    lane = int'(a % 4);
`ifdef DMEM_MISALIGN_TRAP_EN
    trap = !b && (a % 4 != 0);
`else
    trap = 1'b0;
`endif
    @(negedge clk);
    chk("idle_busy", 32'(busy_s[d]), 32'd0);
    chk("idle_ready", 32'(ready_s[d]), 32'd0);
    req_s[d] = 1'b1; we_s[d] = w; be_s[d] = b; addr_s[d] = a; wdata_s[d] = wd;
    @(posedge clk);
    #1;
    req_s[d] = 1'b0; we_s[d] = 1'($urandom); be_s[d] = 1'($urandom);
    addr_s[d] = $urandom; wdata_s[d] = $urandom;
    got = -1;
    for (int c = 0; c <= lat_m[d] + 3 && got < 0; c++) begin
      @(negedge clk);
      if (ready_s[d]) got = c;
    end
    chk("latency", 32'(got), 32'(lat_m[d]));
    word = mem_m[d][idx];
    mask = 32'hFF << (8 * lane);
    if (!trap) begin
      if (w) mem_m[d][idx] = b ? ((word & ~mask) | ((wd & 32'hFF) << (8 * lane))) : wd;
      else   rdata_m[d]    = b ? ((word >> (8 * lane)) & 32'hFF) : word;
    end
    if (got >= 0) begin
      chk("resp_busy", 32'(busy_s[d]), 32'd1);
      chk("resp_rdata", rdata_s[d], rdata_m[d]);
      chk("resp_err", 32'(err_s[d]), 32'(trap));
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_s[d] = 1'b0; we_s[d] = 1'b0; be_s[d] = 1'b0; addr_s[d] = '0; wdata_s[d] = '0;
      rdata_m[d] = '0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    repeat (5) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("rst_ready", 32'(ready_s[d]), 32'd0);
        chk("rst_busy", 32'(busy_s[d]), 32'd0);
        chk("rst_rdata", rdata_s[d], 32'd0);
        chk("rst_err", 32'(err_s[d]), 32'd0);
      end
    end

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NW; i++) xfer(d, 1'b1, 1'b0, 32'(i * 4), $urandom);

    xfer(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    xfer(0, 1'b0, 1'b0, 32'h10, 32'h0);
    chk("word_rd_10", rdata_s[0], 32'hDEADBEEF);

    xfer(0, 1'b1, 1'b0, 32'h20, 32'h11223344);
    xfer(0, 1'b1, 1'b1, 32'h22, 32'h000000AA);
    xfer(0, 1'b0, 1'b0, 32'h20, 32'h0);
    chk("lane_word", rdata_s[0], 32'h11AA3344);
    xfer(0, 1'b0, 1'b1, 32'h23, 32'h0);
    chk("lane_byte", rdata_s[0], 32'h00000011);

    // Zero-latency instance with req held high: one completion every other cycle.
    @(negedge clk);
    req_s[1] = 1'b1; we_s[1] = 1'b0; be_s[1] = 1'b0; addr_s[1] = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("held_req_ready", 32'(ready_s[1]), 32'(c % 2));
    end
    req_s[1] = 1'b0;
    rdata_m[1] = mem_m[1][0];
    xfer(1, 1'b1, 1'b1, 32'h100, 32'h55);
    xfer(1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wrap_lane0", {24'b0, rdata_s[1][7:0]}, 32'h55);

    xfer(0, 1'b1, 1'b0, 32'h0A, 32'h12345678);
    xfer(0, 1'b0, 1'b0, 32'h08, 32'h0);

    // Abort a write with reset while it is still waiting.
    @(negedge clk);
    req_s[0] = 1'b1; we_s[0] = 1'b1; be_s[0] = 1'b0; addr_s[0] = 32'h08; wdata_s[0] = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_s[0] = 1'b0;
    @(negedge clk);
    chk("abort_wait_ready", 32'(ready_s[0]), 32'd0);
    chk("abort_wait_busy", 32'(busy_s[0]), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    rdata_m[0] = '0;
    rdata_m[1] = '0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_ready", 32'(ready_s[0]), 32'd0);
      chk("abort_busy", 32'(busy_s[0]), 32'd0);
      chk("abort_rdata", rdata_s[0], 32'd0);
    end
    xfer(0, 1'b0, 1'b0, 32'h08, 32'h0);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 80; i++)
        xfer(d, 1'($urandom), 1'($urandom), $urandom, $urandom);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
